// File: rtl/pkt_fifo_pkg.sv
// rtl/pkt_fifo_pkg.sv - shared state encodings and word layout for pkt_fifo_ctrl
package pkt_fifo_pkg;

  typedef enum logic {
    W_RECV = 1'b0,
    W_DROP = 1'b1
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_VALID = 2'd2
  } r_state_t;

  localparam int unsigned DATA_W_DEFAULT = 19;
  localparam int unsigned EOP_BIT_DEFAULT = DATA_W_DEFAULT;

  // The EOP flag sits directly above the payload in each stored word.
  function automatic int unsigned eop_bit(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with exposed pointers and optional write-pointer rewind
module fifo_sync #(
  parameter int ADDR_WIDTH         = 4,
  parameter int W_EL               = 8,
  parameter int CAN_RESET_POINTERS = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wen,
  input  logic [W_EL-1:0]       wdata,
  input  logic                  ren,
  input  logic                  wrst,
  input  logic [ADDR_WIDTH:0]   rst_wptr,
  output logic [W_EL-1:0]       rdata,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH:0]   rptr
);

  logic [W_EL-1:0] mem [2**ADDR_WIDTH];

  // Pointers carry one extra bit so full and empty differ without a counter.
  assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                 (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign rdata = mem[rptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (wen && !full) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if ((CAN_RESET_POINTERS != 0) && wrst) begin
        wptr <= rst_wptr;
      end else if (wen && !full) begin
        wptr <= wptr + 1'b1;
      end
      if (ren) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_fifo_ctrl.sv
// rtl/pkt_fifo_ctrl.sv - packet FIFO that only releases fully committed packets; PKT_FIFO_CTRL_STATS_EN adds commit/drop counters
module pkt_fifo_ctrl
  import pkt_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_eop,
  input  logic              in_drop,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eop,
  input  logic              out_ready
`ifdef PKT_FIFO_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_committed,
  output logic [31:0]       stat_dropped
`endif
);

  localparam int unsigned EOP = eop_bit(DATA_W);

  w_state_t            w_state;
  r_state_t            r_state;
  logic [ADDR_WIDTH:0] commit_ptr;
  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic [ADDR_WIDTH:0] rptr_next;
  logic [DATA_W:0]     wdata;
  logic [DATA_W:0]     rdata;
  logic                full;
  logic                in_acc;
  logic                wen;
  logic                ren;
  logic                wrst;
  logic                commit_now;

  assign in_ready   = (w_state == W_DROP) || !full;
  assign in_acc     = in_valid && in_ready;
  assign wen        = in_acc && (w_state == W_RECV) && !(in_eop && in_drop);
  assign commit_now = wen && in_eop;
  // A drop rewinds the write pointer on the same edge so the next packet can start immediately.
  assign wrst       = in_acc && in_eop && ((w_state == W_DROP) || in_drop);
  assign wdata      = {in_eop, in_data};
  assign ren        = (r_state == R_VALID) && out_ready;
  assign rptr_next  = rptr + 1'b1;

  fifo_sync #(
    .ADDR_WIDTH         (ADDR_WIDTH),
    .W_EL               (DATA_W + 1),
    .CAN_RESET_POINTERS (1)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wen      (wen),
    .wdata    (wdata),
    .ren      (ren),
    .wrst     (wrst),
    .rst_wptr (commit_ptr),
    .rdata    (rdata),
    .full     (full),
    .wptr     (wptr),
    .rptr     (rptr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state    <= W_RECV;
      commit_ptr <= '0;
    end else begin
      case (w_state)
        W_RECV: begin
          if (in_valid && full) begin
            w_state <= W_DROP;
          end else if (commit_now) begin
            commit_ptr <= wptr + 1'b1;
          end
        end
        W_DROP: begin
          if (in_acc && in_eop) begin
            w_state <= W_RECV;
          end
        end
        default: w_state <= W_RECV;
      endcase
    end
  end

  // Only words below commit_ptr are visible, so a packet never egresses before its eop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= R_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eop   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rptr != commit_ptr) begin
            r_state <= R_FETCH;
          end
        end
        R_FETCH: begin
          r_state   <= R_VALID;
          out_valid <= 1'b1;
          out_data  <= rdata[DATA_W-1:0];
          out_eop   <= rdata[EOP];
        end
        R_VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= (rptr_next != commit_ptr) ? R_FETCH : R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef PKT_FIFO_CTRL_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_committed <= '0;
      stat_dropped   <= '0;
    end else begin
      if (commit_now && (stat_committed != 32'hFFFF_FFFF)) begin
        stat_committed <= stat_committed + 32'd1;
      end
      if (wrst && (stat_dropped != 32'hFFFF_FFFF)) begin
        stat_dropped <= stat_dropped + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// tb/tb_pkt_fifo_ctrl.sv - self-checking bench for pkt_fifo_ctrl (ADDR_WIDTH=3)
module tb_pkt_fifo_ctrl;
  import pkt_fifo_pkg::*;

  localparam int AW    = 3;
  localparam int DW    = 19;
  localparam int DEPTH = 2**AW;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_eop;
  logic          in_drop;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_eop;
  logic          out_ready;
`ifdef PKT_FIFO_CTRL_STATS_EN
  logic [31:0]   stat_committed;
  logic [31:0]   stat_dropped;
`endif

  int checks = 0;
  int fails  = 0;
  int ren_cnt = 0;
  logic [DW:0] got_q[$];

  pkt_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_eop    (in_eop),
    .in_drop   (in_drop),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_eop   (out_eop),
    .out_ready (out_ready)
`ifdef PKT_FIFO_CTRL_STATS_EN
    ,
    .stat_committed (stat_committed),
    .stat_dropped   (stat_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back({out_eop, out_data});
    if (dut.ren === 1'b1) ren_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ie;
    logic          idr;
    logic          ordy;
    logic          e_irdy;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_oe;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_eop = 1'b0; in_drop = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic e, input logic dr);
    logic rdy;
    rdy = 1'b0;
    in_valid = 1'b1; in_data = d; in_eop = e; in_drop = dr;
    for (int n = 0; n < 40; n++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
    end
    in_valid = 1'b0; in_eop = 1'b0; in_drop = 1'b0;
    if (!rdy) chk("send_accept", 32'(rdy), 32'd1);
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 40; n++) begin
      if (in_ready) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_out(input int n_words);
    for (int n = 0; n < 100; n++) begin
      if (got_q.size() >= n_words) break;
      @(posedge clk); #1;
    end
    chk("egress_count", 32'(got_q.size()), 32'(n_words));
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 20; n++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic chk_got(input string nm, input int idx, input logic [DW:0] exp);
    if (got_q.size() > idx) chk(nm, 32'(got_q[idx]), 32'(exp));
    else chk(nm, 32'h0010_0000 | 32'(got_q.size()), 32'(exp));
  endtask

  // Random phase: reference model of committed / open packets with word-level occupancy.
  task automatic random_phase();
    logic [DW:0] exp_q[$];
    logic [DW:0] open_q[$];
    int occ, rem;
    logic drop_mode, hold, exp_rdy, acc_in, acc_out;
    occ = 0; rem = 0; drop_mode = 1'b0; hold = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      exp_rdy = drop_mode || (occ < DEPTH);
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      if (out_valid) chk("rnd_out_word", 32'({out_eop, out_data}),
                         (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0010_0000);
      if (c >= 1400) begin
        in_valid = 1'b0;
      end else if (!hold) begin
        if (rem == 0) rem = $urandom_range(1, 10);
        in_valid = ($urandom_range(3) != 0);
        in_data  = DW'($urandom);
        in_eop   = (rem == 1);
        in_drop  = in_eop && ($urandom_range(4) == 0);
      end
      out_ready = (c >= 1400) || ($urandom_range(9) < 6);
      acc_in  = in_valid && exp_rdy;
      acc_out = out_valid && out_ready;
      if (acc_out && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        occ--;
      end
      if (in_valid && !exp_rdy) begin
        drop_mode = 1'b1;
      end else if (acc_in) begin
        rem--;
        if (drop_mode) begin
          if (in_eop) begin
            drop_mode = 1'b0;
            occ -= open_q.size();
            open_q.delete();
          end
        end else if (in_eop && in_drop) begin
          occ -= open_q.size();
          open_q.delete();
        end else begin
          open_q.push_back({in_eop, in_data});
          occ++;
          if (in_eop) begin
            foreach (open_q[k]) exp_q.push_back(open_q[k]);
            open_q.delete();
          end
        end
      end
      hold = in_valid && !acc_in;
      @(posedge clk); #1;
    end
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 19'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'h0, 1'b0};
    vecs[1]  = '{1'b1, 19'h2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'h0, 1'b0};
    vecs[2]  = '{1'b1, 19'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 19'h0, 1'b0};
    vecs[3]  = '{1'b0, 19'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'h0, 1'b0};
    vecs[4]  = '{1'b0, 19'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 19'h1, 1'b0};
    vecs[5]  = '{1'b0, 19'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'h0, 1'b0};
    vecs[6]  = '{1'b0, 19'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 19'h2, 1'b0};
    vecs[7]  = '{1'b0, 19'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'h0, 1'b0};
    vecs[8]  = '{1'b0, 19'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 19'h3, 1'b1};
    vecs[9]  = '{1'b0, 19'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'h0, 1'b0};
    vecs[10] = '{1'b0, 19'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'h0, 1'b0};

    // Reset state
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_eop", 32'(out_eop), 32'd0);

    // 3-word packet, cycle-exact
    foreach (vecs[i]) begin
      in_valid = vecs[i].iv; in_data = vecs[i].id; in_eop = vecs[i].ie;
      in_drop = vecs[i].idr; out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      chk("vec_in_ready", 32'(in_ready), 32'(vecs[i].e_irdy));
      chk("vec_out_valid", 32'(out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk("vec_out_word", 32'({out_eop, out_data}), 32'({vecs[i].e_oe, vecs[i].e_od}));
    end
    in_valid = 1'b0;

    // Committed A then dropped B
    do_reset(); got_q.delete();
    send_word(19'h41, 1'b0, 1'b0); send_word(19'h42, 1'b1, 1'b0);
    send_word(19'h51, 1'b0, 1'b0); send_word(19'h52, 1'b0, 1'b0);
    send_word(19'h53, 1'b0, 1'b0); send_word(19'h54, 1'b1, 1'b1);
    chk("drop_commit_ptr", 32'(dut.commit_ptr), 32'd2);
    chk("drop_wptr", 32'(dut.u_fifo.wptr), 32'd2);
    out_ready = 1'b1;
    wait_out(2);
    chk_got("drop_a0", 0, {1'b0, 19'h41});
    chk_got("drop_a1", 1, {1'b1, 19'h42});
    send_word(19'h61, 1'b1, 1'b0);
    wait_out(3);
    chk_got("drop_c0", 2, {1'b1, 19'h61});
    chk("drop_commit_c", 32'(dut.commit_ptr), 32'd3);

    // Oversized packet overflows into W_DROP
    do_reset(); got_q.delete();
    for (int i = 0; i < 8; i++) send_word(19'h70 + 19'(i), 1'b0, 1'b0);
    chk("ovf_full_ready", 32'(in_ready), 32'd0);
    send_word(19'h78, 1'b0, 1'b0);
    chk("ovf_w_drop", 32'(dut.w_state), 32'(W_DROP));
    send_word(19'h79, 1'b1, 1'b0);
    chk("ovf_wptr", 32'(dut.u_fifo.wptr), 32'd0);
    chk("ovf_w_recv", 32'(dut.w_state), 32'(W_RECV));
    repeat (8) @(posedge clk);
    #1;
    chk("ovf_no_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send_word(19'h81, 1'b0, 1'b0); send_word(19'h82, 1'b0, 1'b0); send_word(19'h83, 1'b1, 1'b0);
    wait_out(3);
    chk_got("ovf_n0", 0, {1'b0, 19'h81});
    chk_got("ovf_n1", 1, {1'b0, 19'h82});
    chk_got("ovf_n2", 2, {1'b1, 19'h83});

    // Backpressure in R_VALID
    do_reset(); got_q.delete();
    send_word(19'h31, 1'b0, 1'b0); send_word(19'h32, 1'b1, 1'b0);
    wait_valid();
    begin
      int r0;
      r0 = ren_cnt;
      repeat (5) begin
        @(posedge clk); #1;
        chk("hold_word", 32'({out_eop, out_data}), 32'h31);
        chk("hold_valid", 32'(out_valid), 32'd1);
      end
      chk("hold_no_ren", 32'(ren_cnt), 32'(r0));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("hold_one_ren", 32'(ren_cnt), 32'(r0 + 1));
      chk_got("hold_got", 0, {1'b0, 19'h31});
    end

    // 20 single-word packets across pointer wrap
    do_reset(); got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_ready();
      send_word(19'(i), 1'b1, 1'b0);
    end
    wait_out(20);
    for (int i = 0; i < 20; i++) chk_got("wrap_word", i, {1'b1, 19'(i)});
    chk("wrap_wptr", 32'(dut.u_fifo.wptr), 32'd4);

    // Reset mid-packet while out_valid is high
    do_reset(); got_q.delete();
    send_word(19'h11, 1'b0, 1'b0); send_word(19'h12, 1'b1, 1'b0);
    wait_valid();
    send_word(19'h13, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    got_q.delete();
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("arst_no_stale", 32'(got_q.size()), 32'd0);
    send_word(19'h21, 1'b0, 1'b0); send_word(19'h22, 1'b1, 1'b0);
    wait_out(2);
    chk_got("arst_new0", 0, {1'b0, 19'h21});
    chk_got("arst_new1", 1, {1'b1, 19'h22});

    // Randomized traffic against the packet-level model
    do_reset();
    random_phase();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
